// File: rtl/snn_pkg.sv
// Shared definitions for the LIF spiking layer: controller states, default
// parameter values and the signed saturation helper.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_OUTPUT = 2'd2
    } lif_state_t;

    localparam int SNN_N_INPUT      = 4;
    localparam int SNN_N_OUTPUT     = 3;
    localparam int SNN_W_WIDTH      = 8;
    localparam int SNN_V_WIDTH      = 16;
    localparam int SNN_THRESHOLD    = 64;
    localparam int SNN_LEAK_SHIFT   = 3;
    localparam int SNN_REFRAC_STEPS = 2;

    // Clamp a wide signed value into the range of a 'width'-bit signed number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leak/integrate/threshold step for one LIF neuron.
// Refractory handling is present only when LIF_REFRACTORY_EN is defined.
module lif_update
    import snn_pkg::*;
#(
    parameter int N_INPUT    = SNN_N_INPUT,
    parameter int W_WIDTH    = SNN_W_WIDTH,
    parameter int V_WIDTH    = SNN_V_WIDTH,
    parameter int THRESHOLD  = SNN_THRESHOLD,
    parameter int LEAK_SHIFT = SNN_LEAK_SHIFT,
`ifdef LIF_REFRACTORY_EN
    parameter int REFRAC_STEPS = SNN_REFRAC_STEPS,
    parameter int CNT_W        = 2,
`endif
    parameter int I_WIDTH    = W_WIDTH + $clog2(N_INPUT) + 1
) (
    input  logic signed [V_WIDTH-1:0]         v,
    input  logic        [N_INPUT-1:0]         spikes,
    input  logic        [N_INPUT*W_WIDTH-1:0] weights,
`ifdef LIF_REFRACTORY_EN
    input  logic        [CNT_W-1:0]           refrac,
    output logic        [CNT_W-1:0]           refrac_next,
`endif
    output logic signed [V_WIDTH-1:0]         v_next,
    output logic                              spike
);

    // Wide enough that v - leak + current can never overflow before clamping.
    localparam int SW = ((V_WIDTH > I_WIDTH) ? V_WIDTH : I_WIDTH) + 2;
    localparam logic signed [V_WIDTH-1:0] TH = V_WIDTH'(THRESHOLD);

    logic signed [I_WIDTH-1:0] current;
    logic signed [SW-1:0]      v_ext;
    logic signed [SW-1:0]      leak;
    logic signed [SW-1:0]      sum;
    logic signed [V_WIDTH-1:0] v_sat;
    logic                      fire;

    always_comb begin
        current = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            if (spikes[i]) begin
                current = current + I_WIDTH'(signed'(weights[i*W_WIDTH +: W_WIDTH]));
            end
        end
        v_ext  = SW'(v);
        leak   = v_ext >>> LEAK_SHIFT;
        sum    = v_ext - leak + SW'(current);
        v_sat  = V_WIDTH'(sat_signed(64'(sum), V_WIDTH));
        fire   = (v_sat >= TH);
        v_next = fire ? '0 : v_sat;
        spike  = fire;
`ifdef LIF_REFRACTORY_EN
        refrac_next = refrac;
        if (refrac != '0) begin
            v_next      = '0;
            spike       = 1'b0;
            refrac_next = refrac - CNT_W'(1);
        end else if (fire) begin
            refrac_next = CNT_W'(REFRAC_STEPS);
        end
`endif
    end

endmodule

// File: rtl/lif_spiking_layer.sv
// Layer of N_OUTPUT LIF neurons sharing one time-multiplexed lif_update datapath.
// Define LIF_REFRACTORY_EN to add per-neuron refractory counters.
module lif_spiking_layer
    import snn_pkg::*;
#(
    parameter int N_INPUT      = SNN_N_INPUT,
    parameter int N_OUTPUT     = SNN_N_OUTPUT,
    parameter int W_WIDTH      = SNN_W_WIDTH,
    parameter int V_WIDTH      = SNN_V_WIDTH,
    parameter int THRESHOLD    = SNN_THRESHOLD,
    parameter int LEAK_SHIFT   = SNN_LEAK_SHIFT,
    parameter int REFRAC_STEPS = SNN_REFRAC_STEPS
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [N_INPUT-1:0]                                in_spikes,
    input  logic                                              w_we,
    input  logic [((N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1)-1:0] w_addr_out,
    input  logic [((N_INPUT > 1) ? $clog2(N_INPUT) : 1)-1:0]   w_addr_in,
    input  logic signed [W_WIDTH-1:0]                         w_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [N_OUTPUT-1:0]                               out_spikes
);

    localparam int AOW   = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
    localparam int AIW   = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam int CNT_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam logic [AOW-1:0] LAST = AOW'(N_OUTPUT - 1);

    if (REFRAC_STEPS < 0 || LEAK_SHIFT < 0 || LEAK_SHIFT >= V_WIDTH) begin : g_param_check
        $error("lif_spiking_layer: REFRAC_STEPS or LEAK_SHIFT out of range");
    end

    lif_state_t state;
    lif_state_t state_next;

    logic        [N_INPUT-1:0]         spikes_lat;
    logic        [AOW-1:0]             idx;
    logic        [N_OUTPUT-1:0]        spikes_out;
    logic signed [W_WIDTH-1:0]         weights   [N_OUTPUT][N_INPUT];
    logic signed [V_WIDTH-1:0]         potential [N_OUTPUT];
    logic        [N_INPUT*W_WIDTH-1:0] row;
    logic signed [V_WIDTH-1:0]         v_next;
    logic                              spike;
    logic                              accept;
    logic                              write_ok;
`ifdef LIF_REFRACTORY_EN
    logic        [CNT_W-1:0]           refrac [N_OUTPUT];
    logic        [CNT_W-1:0]           refrac_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (idx == LAST) begin
                    state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept   = (state == ST_IDLE) && in_valid;
    assign write_ok = (state == ST_IDLE) && w_we &&
                      (32'(w_addr_out) < N_OUTPUT) && (32'(w_addr_in) < N_INPUT);

    // Select the weight row of the neuron currently being updated.
    always_comb begin
        row = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            row[i*W_WIDTH +: W_WIDTH] = weights[idx][i];
        end
    end

    lif_update #(
        .N_INPUT      (N_INPUT),
        .W_WIDTH      (W_WIDTH),
        .V_WIDTH      (V_WIDTH),
        .THRESHOLD    (THRESHOLD),
`ifdef LIF_REFRACTORY_EN
        .REFRAC_STEPS (REFRAC_STEPS),
        .CNT_W        (CNT_W),
`endif
        .LEAK_SHIFT   (LEAK_SHIFT)
    ) u_update (
        .v           (potential[idx]),
        .spikes      (spikes_lat),
        .weights     (row),
`ifdef LIF_REFRACTORY_EN
        .refrac      (refrac[idx]),
        .refrac_next (refrac_next),
`endif
        .v_next      (v_next),
        .spike       (spike)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spikes_lat <= '0;
            idx        <= '0;
            spikes_out <= '0;
            for (int j = 0; j < N_OUTPUT; j++) begin
                potential[j] <= '0;
`ifdef LIF_REFRACTORY_EN
                refrac[j]    <= '0;
`endif
                for (int i = 0; i < N_INPUT; i++) begin
                    weights[j][i] <= '0;
                end
            end
        end else begin
            // A write in the accept cycle lands before UPDATE reads the weights.
            if (write_ok) begin
                weights[w_addr_out][w_addr_in] <= w_data;
            end
            if (accept) begin
                spikes_lat <= in_spikes;
                idx        <= '0;
                spikes_out <= '0;
            end
            if (state == ST_UPDATE) begin
                potential[idx]  <= v_next;
                spikes_out[idx] <= spike;
`ifdef LIF_REFRACTORY_EN
                refrac[idx]     <= refrac_next;
`endif
                idx             <= idx + AOW'(1);
            end
        end
    end

    assign out_spikes = spikes_out;

endmodule

// File: tb/tb_lif_spiking_layer.sv
// Self-checking bench for lif_spiking_layer (V_WIDTH = 10) against a plain
// arithmetic model of the leaky integrate-and-fire rules.
module tb_lif_spiking_layer;

    localparam int VMAX = 511;
    localparam int VMIN = -512;
    localparam int TH   = 64;
    localparam int LEAK = 3;
    localparam int RS   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_spikes;
    logic              w_we;
    logic [1:0]        w_addr_out;
    logic [1:0]        w_addr_in;
    logic signed [7:0] w_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_spikes;

    int n_cmp = 0;
    int n_bad = 0;

    int w_m  [3][4];
    int v_m  [3];
    int rc_m [3];

    always #5 clk = ~clk;

    lif_spiking_layer #(.V_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_spikes  (in_spikes),
        .w_we       (w_we),
        .w_addr_out (w_addr_out),
        .w_addr_in  (w_addr_in),
        .w_data     (w_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_spikes (out_spikes)
    );

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            v_m[j]  = 0;
            rc_m[j] = 0;
            for (int i = 0; i < 4; i++) w_m[j][i] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] s, output logic [2:0] exp_spk);
        int cur;
        int nv;
        exp_spk = 3'b000;
        for (int j = 0; j < 3; j++) begin
`ifdef LIF_REFRACTORY_EN
            if (rc_m[j] > 0) begin
                rc_m[j] = rc_m[j] - 1;
                v_m[j]  = 0;
                continue;
            end
`endif
            cur = 0;
            for (int i = 0; i < 4; i++) if (s[i]) cur += w_m[j][i];
            nv = v_m[j] - (v_m[j] >>> LEAK) + cur;
            if (nv > VMAX) nv = VMAX;
            if (nv < VMIN) nv = VMIN;
            if (nv >= TH) begin
                exp_spk[j] = 1'b1;
                v_m[j]     = 0;
                rc_m[j]    = RS;
            end else begin
                v_m[j] = nv;
            end
        end
    endtask

    task automatic write_weight(input int wo, input int wi, input int wd);
        w_we       = 1'b1;
        w_addr_out = wo[1:0];
        w_addr_in  = wi[1:0];
        w_data     = wd[7:0];
        @(posedge clk); #1;
        w_we = 1'b0;
        if (wo < 3 && wi < 4) w_m[wo][wi] = wd;
    endtask

    // One full timestep: optional weight write in the accept cycle, then handshake.
    task automatic run_step(input logic [3:0] s, input logic we, input int wo, input int wi,
                            input int wd, output logic [2:0] spk, output int lat);
        w_we       = we;
        w_addr_out = wo[1:0];
        w_addr_in  = wi[1:0];
        w_data     = wd[7:0];
        in_valid   = 1'b1;
        in_spikes  = s;
        @(posedge clk); #1;
        if (we && wo < 3 && wi < 4) w_m[wo][wi] = wd;
        in_valid  = 1'b0;
        w_we      = 1'b0;
        in_spikes = 4'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL step_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
        spk = out_spikes;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_spikes = '0; w_we = 1'b0; w_addr_out = '0;
        w_addr_in = '0; w_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_spikes !== 3'b000) begin n_bad++; $display("FAIL reset_out_spikes: got %b want 000", out_spikes); end
        @(posedge clk); #1;
    endtask

    task automatic test_firing();
        logic [2:0] want [6];
        logic [2:0] spk;
        logic [2:0] exp_spk;
        int lat;
`ifdef LIF_REFRACTORY_EN
        want = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
`else
        want = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001};
`endif
        write_weight(0, 0, 40);
        for (int k = 0; k < 6; k++) begin
            run_step(4'b0001, 1'b0, 0, 0, 0, spk, lat);
            model_step(4'b0001, exp_spk);
            n_cmp++;
            if (spk !== want[k]) begin
                n_bad++;
                $display("FAIL firing_step%0d: out_spikes=%b want %b", k + 1, spk, want[k]);
            end
            if (k == 0) begin
                n_cmp++;
                if (lat !== 3) begin n_bad++; $display("FAIL firing_latency: got %0d cycles want 3", lat); end
                n_cmp++;
                if (int'(dut.potential[0]) !== 40) begin
                    n_bad++; $display("FAIL firing_v_step1: v0=%0d want 40", dut.potential[0]);
                end
            end
        end
    endtask

    task automatic test_leak();
        int want_v [4] = '{16, 14, 13, 12};
        logic [3:0] s;
        logic [2:0] spk;
        logic [2:0] exp_spk;
        int lat;
        write_weight(1, 2, 16);
        for (int k = 0; k < 4; k++) begin
            s = (k == 0) ? 4'b0100 : 4'b0000;
            run_step(s, 1'b0, 0, 0, 0, spk, lat);
            model_step(s, exp_spk);
            n_cmp++;
            if (int'(dut.potential[1]) !== want_v[k]) begin
                n_bad++; $display("FAIL leak_v1_step%0d: v1=%0d want %0d", k + 1, dut.potential[1], want_v[k]);
            end
            n_cmp++;
            if (spk !== exp_spk) begin
                n_bad++; $display("FAIL leak_spikes_step%0d: got %b want %b", k + 1, spk, exp_spk);
            end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] spk;
        logic [2:0] exp_spk;
        int lat;
        for (int i = 0; i < 4; i++) write_weight(2, i, -128);
        for (int k = 0; k < 6; k++) begin
            run_step(4'b1111, 1'b0, 0, 0, 0, spk, lat);
            model_step(4'b1111, exp_spk);
            n_cmp++;
            if (int'(dut.potential[2]) !== -512) begin
                n_bad++; $display("FAIL sat_v2_step%0d: v2=%0d want -512", k + 1, dut.potential[2]);
            end
            n_cmp++;
            if (spk !== exp_spk || spk[2] !== 1'b0) begin
                n_bad++; $display("FAIL sat_spikes_step%0d: got %b want %b", k + 1, spk, exp_spk);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_spk;
        logic [2:0] held;
        int lat;
        in_valid  = 1'b1;
        in_spikes = 4'b0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_step(4'b0001, exp_spk);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        held = out_spikes;
        n_cmp++;
        if (held !== exp_spk) begin n_bad++; $display("FAIL bp_spikes: got %b want %b", held, exp_spk); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_spikes = 4'($urandom);
            w_we = 1'b1; w_addr_out = 2'd0; w_addr_in = 2'd1; w_data = 8'sd99;
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_spikes !== held || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_c%0d: valid=%b spikes=%b ready=%b want 1 %b 0",
                         c, out_valid, out_spikes, in_ready, held);
            end
        end
        in_valid = 1'b0; w_we = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        n_cmp++;
        if (int'(dut.weights[0][1]) !== 0) begin
            n_bad++; $display("FAIL bp_write_ignored: w[0][1]=%0d want 0", dut.weights[0][1]);
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] spk;
        logic [2:0] exp_spk;
        int lat;
        in_valid = 1'b1; in_spikes = 4'b1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_spikes !== 3'b000) begin
            n_bad++; $display("FAIL midrst_outputs: valid=%b spikes=%b want 0 000", out_valid, out_spikes);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (int'(dut.potential[j]) !== 0) begin
                n_bad++; $display("FAIL midrst_v%0d: got %0d want 0", j, dut.potential[j]);
            end
        end
        write_weight(0, 0, 40);
        run_step(4'b0001, 1'b0, 0, 0, 0, spk, lat);
        model_step(4'b0001, exp_spk);
        n_cmp++;
        if (spk !== 3'b000 || int'(dut.potential[0]) !== 40) begin
            n_bad++; $display("FAIL midrst_step1: spikes=%b v0=%0d want 000 40", spk, dut.potential[0]);
        end
        run_step(4'b0001, 1'b0, 0, 0, 0, spk, lat);
        model_step(4'b0001, exp_spk);
        n_cmp++;
        if (spk !== 3'b001) begin n_bad++; $display("FAIL midrst_step2: spikes=%b want 001", spk); end
    endtask

    task automatic test_random();
        logic [3:0] s;
        logic [2:0] spk;
        logic [2:0] exp_spk;
        logic       we;
        int lat, wo, wi, wd;
        for (int k = 0; k < 40; k++) begin
            s  = 4'($urandom);
            we = 1'($urandom);
            wo = $urandom_range(0, 3);
            wi = $urandom_range(0, 3);
            wd = $urandom_range(0, 255) - 128;
            run_step(s, we, wo, wi, wd, spk, lat);
            model_step(s, exp_spk);
            n_cmp++;
            if (spk !== exp_spk) begin
                n_bad++; $display("FAIL rand_spikes_%0d: got %b want %b", k, spk, exp_spk);
            end
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (int'(dut.potential[j]) !== v_m[j]) begin
                    n_bad++; $display("FAIL rand_v%0d_%0d: got %0d want %0d", j, k, dut.potential[j], v_m[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_firing();
        test_leak();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lif_spiking_layer.md
LIF_SPIKING_LAYER -- requirements
Module: lif_spiking_layer

Interface
REQ-001 SHALL have parameter N_INPUT, default 4, number of input spike lines.
REQ-002 SHALL have parameter N_OUTPUT, default 3, number of LIF neurons.
REQ-003 SHALL have parameter W_WIDTH, default 8, signed synaptic weight width.
REQ-004 SHALL have parameter V_WIDTH, default 16, signed membrane potential width.
REQ-005 SHALL have parameter THRESHOLD, default 64, firing threshold (signed, V_WIDTH).
REQ-006 SHALL have parameter LEAK_SHIFT, default 3, leak arithmetic-shift amount.
REQ-007 SHALL have parameter REFRAC_STEPS, default 2, refractory timesteps after a spike.
REQ-008 SHALL have port clk  input  1  single clock, rising edge.
REQ-009 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-010 SHALL have port in_valid  input  1  timestep input present.
REQ-011 SHALL have port in_ready  output  1  block accepts a timestep.
REQ-012 SHALL have port in_spikes  input  N_INPUT  input spike vector.
REQ-013 SHALL have port w_we  input  1  weight write strobe.
REQ-014 SHALL have port w_addr_out  input  clog2(N_OUTPUT)  target neuron index.
REQ-015 SHALL have port w_addr_in  input  clog2(N_INPUT)  source input index.
REQ-016 SHALL have port w_data  input  W_WIDTH  signed weight value.
REQ-017 SHALL have port out_valid  output  1  output spike vector valid.
REQ-018 SHALL have port out_ready  input  1  consumer accepts output.
REQ-019 SHALL have port out_spikes  output  N_OUTPUT  output spike vector, bit j = neuron j.

Function
REQ-020 SHALL implement FSM IDLE -> UPDATE -> OUTPUT -> IDLE; in_ready = 1 only in IDLE.
REQ-021 SHALL, on in_valid && in_ready, latch in_spikes and enter UPDATE; in_spikes otherwise ignored.
REQ-022 SHALL process one neuron per cycle in UPDATE, index 0..N_OUTPUT-1, then enter OUTPUT; out_valid rises N_OUTPUT cycles after the accept edge.
REQ-023 SHALL compute per neuron: I = sum of w[j][i] over set latched bits i, width W_WIDTH+clog2(N_INPUT)+1; v' = v - (v >>> LEAK_SHIFT) + I, saturated to V_WIDTH signed range, never wrapping.
REQ-024 SHALL, when v' >= THRESHOLD, set out_spikes[j] = 1, set v = 0, and load refractory counter with REFRAC_STEPS.
REQ-025 SHALL, when the refractory counter is nonzero, skip integration, hold v = 0, emit no spike, and decrement the counter once per timestep.
REQ-026 SHALL hold out_valid and out_spikes stable in OUTPUT until out_ready; on out_valid && out_ready, return to IDLE (in_ready high the next cycle).
REQ-027 SHALL write w[w_addr_out][w_addr_in] = w_data on w_we only in IDLE, ignoring writes in other states and out-of-range addresses; a write and accept in the same IDLE cycle applies the write before that timestep is processed.

Reset
REQ-028 SHALL, on rst, asynchronously clear all v, refractory counters, and weights to 0, set FSM IDLE, out_valid = 0, out_spikes = 0; in_ready = 1 after release.
REQ-029 SHALL abandon a timestep in progress when rst asserts mid-UPDATE or mid-OUTPUT, with no partial state retained.

Configuration
REQ-030 SHALL honour macro LIF_REFRACTORY_EN: defined -> REQ-025 active; undefined -> no counters synthesised, neurons integrate every timestep after firing, REFRAC_STEPS ignored.

Structure
REQ-031 SHALL place the FSM state enum, the saturation function, and the default parameter constants in shared package snn_pkg.
REQ-032 SHALL implement the per-neuron leak/integrate/threshold datapath as combinational sub-module lif_update, instantiated once and time-multiplexed.

Verification
REQ-033 SHALL check reset: after rst released -> in_ready = 1, out_valid = 0, out_spikes = 0.
REQ-034 SHALL check firing: w[0][0] = 40, in_spikes = 0001 every step -> v 40, then 75 spike (out_spikes = 001), steps 3-4 silent (refractory), step 5 v = 40, step 6 spike; with LIF_REFRACTORY_EN undefined, spike on steps 2, 4, 6.
REQ-035 SHALL check leak: w[1][2] = 16, one step with 0100, then zeros -> v1 = 16, 14, 13, 12.
REQ-036 SHALL check saturation: V_WIDTH = 10, w[2][0..3] = -128, in_spikes = 1111 repeated -> v clamps at -512, no positive wrap, no spike.
REQ-037 SHALL check backpressure: out_ready low 5 cycles -> out_valid and out_spikes stable, in_ready = 0, concurrent in_valid and w_we ignored.
REQ-038 SHALL check mid-UPDATE reset: rst during neuron 1 -> all outputs 0, in_ready = 1, next timestep behaves as after cold reset.
